// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
// The generator drives positions, syncs and strobes; the consumer supplies the pixel-advance enable.
interface vga_timing_generator_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_sync;
    logic             v_sync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;

    modport master (
        input  en,
        output h_count,
        output v_count,
        output h_sync,
        output v_sync,
        output video_on,
        output line_end,
        output frame_end
    );

    modport slave (
        output en,
        input  h_count,
        input  v_count,
        input  h_sync,
        input  v_sync,
        input  video_on,
        input  line_end,
        input  frame_end
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Horizontal/vertical raster counters with registered sync and active-video decodes
// aligned to the counts, plus combinational line/frame boundary strobes.
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_25MHz,
    input  logic                   rst_n,
    vga_timing_generator_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_period
            $error("vga_timing_generator: every period parameter must be at least 1");
        end
        if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
            longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
            $error("vga_timing_generator: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_sync;
    logic             v_sync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;

    // Next positions are only consumed when en is high, so they assume an advancing pixel.
    always_comb begin
        line_end  = vga.en && (h_count == H_LAST);
        frame_end = line_end && (v_count == V_LAST);
        h_next    = line_end ? '0 : h_count + CNT_W'(1);
        v_next    = v_count;
        if (line_end) begin
            v_next = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
        end
    end

    // Decodes are taken from the next counts so they land on the same edge as the counts they describe.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_count  <= '0;
            v_count  <= '0;
            h_sync   <= ~H_SYNC_POL;
            v_sync   <= ~V_SYNC_POL;
            video_on <= 1'b1;
        end else if (vga.en) begin
            h_count  <= h_next;
            v_count  <= v_next;
            h_sync   <= ((h_next >= H_SYNC_BEGIN) && (h_next < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync   <= ((v_next >= V_SYNC_BEGIN) && (v_next < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            video_on <= (h_next < H_ACT_END) && (v_next < V_ACT_END);
        end
    end

    assign vga.h_count   = h_count;
    assign vga.v_count   = v_count;
    assign vga.h_sync    = h_sync;
    assign vga.v_sync    = v_sync;
    assign vga.video_on  = video_on;
    assign vga.line_end  = line_end;
    assign vga.frame_end = frame_end;

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised raster timing generator that replaces the separate horizontal/vertical counter pair with one block. It owns both counters, decodes the sync pulses, the active-video window and the line/frame boundary strobes, and hands the pixel position to the renderer. It sits directly behind the 25 MHz pixel clock, ahead of the pixel pipeline and the VGA output pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of h_sync (0 = active-low)
- V_SYNC_POL, 0, asserted level of v_sync
- CNT_W, 16, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- clk_25MHz  input  1  pixel clock; the block uses this one clock only
- rst_n  input  1  asynchronous active-low reset
- en  input  1  pixel advance; when low, all state holds
- h_count  output  CNT_W  current pixel column, 0..H_TOTAL-1
- v_count  output  CNT_W  current line, 0..V_TOTAL-1
- h_sync  output  1  horizontal sync at H_SYNC_POL when asserted
- v_sync  output  1  vertical sync at V_SYNC_POL when asserted
- video_on  output  1  high when (h_count, v_count) is inside the active window
- line_end  output  1  one-cycle strobe: en high and h_count = H_TOTAL-1
- frame_end  output  1  one-cycle strobe: line_end high and v_count = V_TOTAL-1

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Every period parameter is ≥1. An elaboration-time check fails if any period is 0 or if either total exceeds 2^CNT_W.
- Horizontal counter: on each clock with en=1, increments and wraps H_TOTAL-1 → 0.
- Vertical counter: advances only on line_end. It increments and wraps V_TOTAL-1 → 0, so both counters reach 0 on the same edge at frame end.
- Horizontal regions: active when h < H_ACTIVE. Sync is asserted when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. Vertical regions use the same rule with V_* parameters.
- h_sync, v_sync and video_on are registers. They are computed from the next counter values, so they always describe the h_count/v_count presented in the same cycle. There is no skew between the counts and these decodes.
- line_end and frame_end are combinational decodes of en and the registered counts. They are never high while en=0.
- en=0: counters, syncs and video_on hold. Strobes are low. On en reassertion, counting resumes from the held position with no skipped or repeated count.
- Reset asserted at any time, including mid-line or mid-sync: all state returns to its reset value immediately (asynchronously). Deassertion takes effect on the next clk_25MHz edge.

## Timing
- Reset values: h_count=0, v_count=0, h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL, video_on=1 (position 0,0 is active). line_end and frame_end are 0 regardless of en.
- Latency from en to a count change is one edge. Decodes change on that same edge.
- Defaults: 800 clocks per line, 525 lines, 420 000 clocks per frame.
- With defaults, h_sync is asserted for h=656..751 and v_sync is asserted for v=490..491. The block does not further qualify v_sync by h.
- line_end is high for exactly one en-qualified cycle per line. frame_end is high for one cycle per frame, coincident with that frame's final line_end.

## Test plan
- Reset then en=1, defaults: h_count sequences 0..799→0. line_end pulses every 800 clocks. frame_end pulses first at clock 419 999 after reset release, then every 420 000.
- Defaults, sync windows: h_sync=0 exactly for h_count 656..751 and 1 otherwise. v_sync=0 for v_count 490..491. video_on=1 only for h<640 and v<480.
- Small config (H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=1): H_TOTAL=8, V_TOTAL=6. h_sync=1 only at h=5,6. Wrap (7,5)→(0,0) coincides with frame_end=1 in the preceding cycle.
- en gating: toggle en randomly on the small config. Counts advance only on en=1 cycles, strobes are never high with en=0, and a scoreboard of en-qualified cycles matches h/v exactly.
- Reset mid-operation: assert rst_n=0 at h=6, v=2. Outputs go to reset values without waiting for a clock edge. After release, the first en cycle gives h_count=1, v_count=0.
- Boundary: hold en=0 at h=H_TOTAL-1. line_end stays 0. On en=1, line_end=1 for one cycle, then h_count=0 and v_count increments.
